// File: rtl/elevator_scan_ctrl.sv
// SCAN-order elevator controller: latches floor calls, tracks the car from
// one-hot floor sensors, drives the motor, times door dwell, reversal settle
// and stall detection off a shared tick prescaler.
module elevator_scan_ctrl #(
  parameter int N_FLOORS     = 4,
  parameter int FLOOR_W      = $clog2(N_FLOORS),
  parameter int CLK_DIV      = 250000,
  parameter int DOOR_TICKS   = 20,
  parameter int SETTLE_TICKS = 2,
  parameter int STALL_TICKS  = 100
) (
  input  logic                CCLK,
  input  logic                rst_n,
  input  logic [N_FLOORS-1:0] req,
  input  logic [N_FLOORS-1:0] sensor,
  output logic [1:0]          motor,
  output logic [FLOOR_W-1:0]  floor,
  output logic                door_open,
  output logic [N_FLOORS-1:0] pending,
  output logic                fault
);

  localparam int CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int T1   = (DOOR_TICKS > SETTLE_TICKS) ? DOOR_TICKS : SETTLE_TICKS;
  localparam int TMAX = (T1 > STALL_TICKS) ? T1 : STALL_TICKS;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {IDLE, MOVE_UP, MOVE_DOWN, STOP, DOOR, SETTLE, FAULT} state_e;
  typedef enum logic {UP, DOWN} dir_e;

  state_e              state, state_nx;
  dir_e                dir, dir_nx;
  logic [CW-1:0]       div_cnt;
  logic                tick;
  logic [N_FLOORS-1:0] sync1, sync2;
  logic [TW-1:0]       tmr, tmr_nx;
  logic [N_FLOORS-1:0] pend_eff, pending_nx, floor_mask;
  logic                sens_valid, arrive;
  logic [FLOOR_W-1:0]  sens_idx;
  logic                any_above, any_below, ahead, behind;

  assign tick       = (div_cnt == CW'(CLK_DIV - 1));
  assign floor_mask = N_FLOORS'(1) << floor;
  assign pend_eff   = pending | req;
  assign ahead      = (dir == UP) ? any_above : any_below;
  assign behind     = (dir == UP) ? any_below : any_above;

  // Tick prescaler: one-cycle pulse every CLK_DIV clocks.
  always_ff @(posedge CCLK or negedge rst_n) begin
    if (!rst_n)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  // Two-flop synchroniser for the asynchronous floor sensors.
  always_ff @(posedge CCLK or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sensor;
      sync2 <= sync1;
    end
  end

  // Sensor decode and request-position summary relative to the current floor.
  always_comb begin
    sens_idx  = '0;
    any_above = 1'b0;
    any_below = 1'b0;
    for (int unsigned i = 0; i < N_FLOORS; i++) begin
      if (sync2[i]) sens_idx = FLOOR_W'(i);
      if (pend_eff[i] && (FLOOR_W'(i) > floor)) any_above = 1'b1;
      if (pend_eff[i] && (FLOOR_W'(i) < floor)) any_below = 1'b1;
    end
    sens_valid = $onehot(sync2);
    arrive     = sens_valid && (sens_idx != floor);
  end

  // Position, request latch, FSM state, direction and shared tick timer.
  always_ff @(posedge CCLK or negedge rst_n) begin
    if (!rst_n) begin
      floor   <= '0;
      pending <= '0;
      state   <= IDLE;
      dir     <= UP;
      tmr     <= '0;
    end else begin
      if (sens_valid) floor <= sens_idx;
      pending <= pending_nx;
      state   <= state_nx;
      dir     <= dir_nx;
      tmr     <= tmr_nx;
    end
  end

  // Next-state, timer and output decode for the SCAN sequencer.
  always_comb begin
    state_nx   = state;
    dir_nx     = dir;
    tmr_nx     = tmr;
    pending_nx = pend_eff;
    motor      = 2'b00;
    door_open  = 1'b0;
    fault      = 1'b0;
    case (state)
      IDLE: begin
        tmr_nx = '0;
        if (pend_eff[floor]) begin
          state_nx   = DOOR;
          pending_nx = pend_eff & ~floor_mask;
        end else if ((dir == UP && any_above) || (dir == DOWN && any_below)) begin
          state_nx = (dir == UP) ? MOVE_UP : MOVE_DOWN;
        end else if (any_above) begin
          state_nx = MOVE_UP;
          dir_nx   = UP;
        end else if (any_below) begin
          state_nx = MOVE_DOWN;
          dir_nx   = DOWN;
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        motor = (state == MOVE_UP) ? 2'b01 : 2'b10;
        if (arrive) begin
          tmr_nx = '0;
          if (pend_eff[sens_idx] ||
              (state == MOVE_UP   && sens_idx == FLOOR_W'(N_FLOORS - 1)) ||
              (state == MOVE_DOWN && sens_idx == '0))
            state_nx = STOP;
        end else if ((state == MOVE_UP   && floor == FLOOR_W'(N_FLOORS - 1)) ||
                     (state == MOVE_DOWN && floor == '0)) begin
          state_nx = STOP;
          tmr_nx   = '0;
        end else if (tick) begin
          if (tmr == TW'(STALL_TICKS - 1)) begin
            state_nx = FAULT;
            tmr_nx   = '0;
          end else begin
            tmr_nx = tmr + 1'b1;
          end
        end
      end
      STOP: begin
        state_nx   = DOOR;
        tmr_nx     = '0;
        pending_nx = pend_eff & ~floor_mask;
      end
      DOOR: begin
        door_open  = 1'b1;
        // A call for this floor during dwell restarts it instead of latching.
        pending_nx = pend_eff & ~floor_mask;
        if (req[floor]) begin
          tmr_nx = '0;
        end else if (tick) begin
          if (tmr == TW'(DOOR_TICKS - 1)) begin
            tmr_nx = '0;
            if (ahead)       state_nx = (dir == UP) ? MOVE_UP : MOVE_DOWN;
            else if (behind) state_nx = SETTLE;
            else             state_nx = IDLE;
          end else begin
            tmr_nx = tmr + 1'b1;
          end
        end
      end
      SETTLE: begin
        if (tick) begin
          if (tmr == TW'(SETTLE_TICKS - 1)) begin
            tmr_nx   = '0;
            dir_nx   = (dir == UP) ? DOWN : UP;
            state_nx = (dir == UP) ? MOVE_DOWN : MOVE_UP;
          end else begin
            tmr_nx = tmr + 1'b1;
          end
        end
      end
      FAULT: begin
        fault = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Bench for elevator_scan_ctrl: a simple car plant answers the motor with
// floor sensors; directed scenarios plus random call batches are checked
// against a SCAN service-order model.
module tb_elevator_scan_ctrl;
  localparam int NF   = 8;
  localparam int FW   = 3;
  localparam int CD   = 4;
  localparam int DT   = 20;
  localparam int ST   = 2;
  localparam int SK   = 100;
  localparam int TRAV = 12;

  logic          CCLK = 1'b0;
  logic          rst_n = 1'b0;
  logic [NF-1:0] req = '0;
  logic [NF-1:0] sensor;
  logic [1:0]    motor;
  logic [FW-1:0] floor;
  logic          door_open;
  logic [NF-1:0] pending;
  logic          fault;

  logic          force_en = 1'b0;
  logic [NF-1:0] force_val = '0;
  int            pos, trav;
  int            overrun = 0;
  int            total = 0;
  int            bad = 0;

  logic [1:0]    prev_motor = 2'b00;
  logic          door_prev = 1'b0;
  int            rev_viol = 0;
  int            door_cnt = 0;
  int            cur_len = 0;
  int            door_flr[512];
  int            door_len[512];

  always #5 CCLK = ~CCLK;

  elevator_scan_ctrl #(
    .N_FLOORS(NF), .CLK_DIV(CD), .DOOR_TICKS(DT),
    .SETTLE_TICKS(ST), .STALL_TICKS(SK)
  ) dut (
    .CCLK(CCLK), .rst_n(rst_n), .req(req), .sensor(sensor),
    .motor(motor), .floor(floor), .door_open(door_open),
    .pending(pending), .fault(fault)
  );

  // Car plant: TRAV clocks per floor, sensor dark between floors.
  always @(posedge CCLK or negedge rst_n) begin
    if (!rst_n) begin
      pos  <= 0;
      trav <= 0;
    end else if (!force_en) begin
      if (motor == 2'b01 || motor == 2'b10) begin
        if (trav == TRAV - 1) begin
          trav <= 0;
          if (motor == 2'b01) begin
            if (pos >= NF - 1) overrun <= overrun + 1;
            else pos <= pos + 1;
          end else begin
            if (pos <= 0) overrun <= overrun + 1;
            else pos <= pos - 1;
          end
        end else begin
          trav <= trav + 1;
        end
      end else begin
        trav <= 0;
      end
    end
  end

  assign sensor = force_en ? force_val : ((trav < 5) ? (NF'(1) << pos) : '0);

  // Observer: motor legality and a log of door openings (floor, length).
  always @(negedge CCLK) begin
    if (motor == 2'b11) rev_viol++;
    if (prev_motor != 2'b00 && motor != 2'b00 && prev_motor != motor) rev_viol++;
    prev_motor = motor;
    if (door_open && !door_prev) begin
      if (door_cnt < 512) door_flr[door_cnt] = int'(floor);
      cur_len = 1;
      door_cnt++;
    end else if (door_open) begin
      cur_len++;
    end else if (door_prev && door_cnt > 0 && door_cnt <= 512) begin
      door_len[door_cnt-1] = cur_len;
    end
    door_prev = door_open;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int v, input int lo, input int hi);
    total++;
    assert (v >= lo && v <= hi) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, v, lo, hi);
    end
  endtask

  task automatic pulse(input logic [NF-1:0] m);
    req = m;
    @(negedge CCLK);
    req = '0;
  endtask

  task automatic wait_door(input logic lvl, input string tag);
    int n = 0;
    while (door_open !== lvl && n < 2000) begin
      @(negedge CCLK);
      n++;
    end
    chk(tag, 32'(door_open), 32'(lvl));
  endtask

  task automatic wait_floor(input int f, input string tag);
    int n = 0;
    while (int'(floor) != f && n < 2000) begin
      @(negedge CCLK);
      n++;
    end
    chk(tag, 32'(floor), f);
  endtask

  task automatic wait_quiet(input string tag);
    int q = 0;
    int n = 0;
    while (q < 3 && n < 3000) begin
      @(negedge CCLK);
      n++;
      if (!door_open && motor == 2'b00 && pending == '0) q++;
      else q = 0;
    end
    chk(tag, q, 3);
  endtask

  initial begin
    int cur;
    logic up;
    logic had_behind;
    int exp_seq[16];
    int en;
    int base;
    int n;
    logic [NF-1:0] m;

    // Reset values
    repeat (3) @(negedge CCLK);
    chk("rst_motor", 32'(motor), 0);
    chk("rst_floor", 32'(floor), 0);
    chk("rst_door", 32'(door_open), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_fault", 32'(fault), 0);
    rst_n = 1'b1;
    repeat (6) @(negedge CCLK);
    chk("idle_motor", 32'(motor), 0);

    // Single call from floor 0 to floor 3
    pulse(8'h08);
    chk("call_motor_up", 32'(motor), 1);
    chk("call_pending", 32'(pending), 'h08);
    wait_door(1'b1, "call_door_rise");
    chk("call_floor", 32'(floor), 3);
    chk("call_stop_motor", 32'(motor), 0);
    chk("call_pending_clr", 32'(pending), 0);
    wait_door(1'b0, "call_door_fall");
    repeat (2) @(negedge CCLK);
    chk_rng("call_dwell", door_len[door_cnt-1], (DT-1)*CD+1, DT*CD);
    chk("call_idle_motor", 32'(motor), 0);

    // Same-floor call and dwell extension at floor 2
    pulse(8'h04);
    wait_quiet("to2_quiet");
    chk("to2_floor", 32'(floor), 2);
    pulse(8'h04);
    chk("same_door", 32'(door_open), 1);
    chk("same_motor", 32'(motor), 0);
    chk("same_pending", 32'(pending), 0);
    repeat (60) @(negedge CCLK);
    chk("same_still_open", 32'(door_open), 1);
    pulse(8'h04);
    chk("same_not_latched", 32'(pending), 0);
    n = 0;
    while (door_open && n < 300) begin
      @(negedge CCLK);
      n++;
    end
    chk_rng("same_extend", n, (DT-1)*CD+1, DT*CD);

    // Multi-hot sensor glitch while passing floor 3
    wait_quiet("glitch_pre_quiet");
    pulse(8'h40);
    chk("glitch_motor_up", 32'(motor), 1);
    wait_floor(3, "glitch_reach3");
    force_val = 8'h18;
    force_en  = 1'b1;
    repeat (8) @(negedge CCLK);
    chk("glitch_floor", 32'(floor), 3);
    chk("glitch_motor", 32'(motor), 1);
    force_en = 1'b0;
    wait_door(1'b1, "glitch_door");
    chk("glitch_dest", 32'(floor), 6);
    wait_quiet("glitch_quiet");

    // SCAN order: moving up past floor 1 with calls at 0 and 3
    pulse(8'h01);
    wait_quiet("scan_home");
    chk("scan_home_floor", 32'(floor), 0);
    pulse(8'h08);
    chk("scan_motor_up", 32'(motor), 1);
    wait_floor(1, "scan_at1");
    pulse(8'h09);
    chk("scan_pending", 32'(pending), 'h09);
    chk("scan_still_up", 32'(motor), 1);
    wait_door(1'b1, "scan_door1");
    chk("scan_first_floor", 32'(floor), 3);
    wait_door(1'b0, "scan_door1_fall");
    n = 0;
    while (motor == 2'b00 && n < 200) begin
      @(negedge CCLK);
      n++;
    end
    chk("scan_settle", n, ST*CD);
    chk("scan_motor_down", 32'(motor), 2);
    wait_door(1'b1, "scan_door2");
    chk("scan_second_floor", 32'(floor), 0);
    wait_quiet("scan_quiet");

    // Reset mid-move, checked before any clock edge
    pulse(8'h40);
    wait_floor(2, "rstmv_at2");
    #2 rst_n = 1'b0;
    #1;
    chk("rstmv_motor", 32'(motor), 0);
    chk("rstmv_pending", 32'(pending), 0);
    chk("rstmv_fault", 32'(fault), 0);
    chk("rstmv_floor", 32'(floor), 0);
    repeat (3) @(negedge CCLK);
    rst_n = 1'b1;
    repeat (8) @(negedge CCLK);
    chk("rstmv_idle_motor", 32'(motor), 0);
    chk("rstmv_idle_pending", 32'(pending), 0);

    // Random call batches against the SCAN order model
    cur = 0;
    up  = 1'b1;
    repeat (10) begin
      m = NF'($urandom_range(1, 255));
      en = 0;
      had_behind = 1'b0;
      if (m[cur]) exp_seq[en++] = cur;
      if (up) begin
        for (int f = cur + 1; f < NF; f++) if (m[f]) exp_seq[en++] = f;
        for (int f = cur - 1; f >= 0; f--) if (m[f]) begin exp_seq[en++] = f; had_behind = 1'b1; end
      end else begin
        for (int f = cur - 1; f >= 0; f--) if (m[f]) exp_seq[en++] = f;
        for (int f = cur + 1; f < NF; f++) if (m[f]) begin exp_seq[en++] = f; had_behind = 1'b1; end
      end
      base = door_cnt;
      pulse(m);
      n = 0;
      while (!(door_cnt == base + en && !door_open && motor == 2'b00) && n < 4000) begin
        @(negedge CCLK);
        n++;
      end
      repeat (3) @(negedge CCLK);
      chk("rnd_doors", door_cnt - base, en);
      for (int k = 0; k < en; k++) begin
        chk("rnd_order", door_flr[base+k], exp_seq[k]);
        chk_rng("rnd_dwell", door_len[base+k], (DT-1)*CD+1, DT*CD);
      end
      cur = exp_seq[en-1];
      if (had_behind) up = ~up;
      chk("rnd_floor", 32'(floor), cur);
      chk("rnd_pending", 32'(pending), 0);
      chk("rnd_motor", 32'(motor), 0);
    end

    // Stall: sensors go dark while moving
    pulse((cur < 4) ? 8'h80 : 8'h01);
    chk("stall_moving", 32'(motor), (cur < 4) ? 1 : 2);
    force_val = '0;
    force_en  = 1'b1;
    n = 0;
    while (!fault && n < 600) begin
      @(negedge CCLK);
      n++;
    end
    chk_rng("stall_time", n, (SK-1)*CD+1, SK*CD);
    chk("stall_fault", 32'(fault), 1);
    chk("stall_motor", 32'(motor), 0);
    chk("stall_door", 32'(door_open), 0);
    pulse(8'h10);
    repeat (20) @(negedge CCLK);
    chk("stall_sticky", 32'(fault), 1);
    chk("stall_sticky_motor", 32'(motor), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("stall_rst_fault", 32'(fault), 0);
    force_en = 1'b0;
    repeat (3) @(negedge CCLK);
    rst_n = 1'b1;
    repeat (4) @(negedge CCLK);
    chk("stall_after_rst", 32'(fault), 0);

    chk("motor_legal", rev_viol, 0);
    chk("no_overrun", overrun, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
